// File: rtl/scandoubler_rotate_membridge.sv
// Bridges the rotating scandoubler's capture (cornerturn write) and linebuffer fetch ports onto one SDRAM client port.
// Optional macro SCANDOUBLER_MEMBRIDGE_RR_EN: round-robin write/read arbitration at burst boundaries.
module scandoubler_rotate_membridge #(
    parameter int unsigned           ADDR_WIDTH = 24,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(24'h200000)
) (
    input  logic                  clk_sys,
    input  logic                  reset,
    input  logic                  vidin_req,
    input  logic                  vidin_frame,
    input  logic [9:0]            vidin_row,
    input  logic [9:0]            vidin_col,
    input  logic [15:0]           vidin_d,
    output logic                  vidin_ack,
    input  logic                  vidout_req,
    input  logic                  vidout_frame,
    input  logic [9:0]            vidout_row,
    input  logic [9:0]            vidout_col,
    output logic [15:0]           vidout_d,
    output logic                  vidout_ack,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_rvalid
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WSETTLE,
        S_WCMD,
        S_WACK,
        S_RCMD,
        S_RDATA
    } state_t;

    state_t      state;
    logic        settle;
    logic [3:0]  wcount;
    logic [2:0]  rcount;
    logic        keep;
    logic        win_block;
    logic        grant_w;
    logic        grant_r;
    logic        keep_next;
    logic [20:0] wr_offs;
    logic [20:0] rd_offs;
`ifdef SCANDOUBLER_MEMBRIDGE_RR_EN
    logic        rr_last_write;
`endif

    // Swapping column and row on the write side is what performs the cornerturn.
    always_comb begin
        wr_offs   = {vidin_frame, vidin_col, vidin_row};
        rd_offs   = {vidout_frame, vidout_row, vidout_col};
        keep_next = keep & vidout_req;
        grant_w   = 1'b0;
        grant_r   = 1'b0;
`ifdef SCANDOUBLER_MEMBRIDGE_RR_EN
        grant_w   = vidin_req & ~win_block & ~(vidout_req & rr_last_write);
        grant_r   = vidout_req & ~grant_w;
`else
        grant_w   = vidin_req & ~win_block;
        grant_r   = vidout_req & ~vidin_req;
`endif
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            settle     <= 1'b0;
            wcount     <= '0;
            rcount     <= '0;
            keep       <= 1'b0;
            win_block  <= 1'b0;
            vidin_ack  <= 1'b0;
            vidout_ack <= 1'b0;
            vidout_d   <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
`ifdef SCANDOUBLER_MEMBRIDGE_RR_EN
            rr_last_write <= 1'b0;
`endif
        end else begin
            vidin_ack  <= 1'b0;
            vidout_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    win_block <= 1'b0;
                    if (grant_w) begin
                        state  <= S_WSETTLE;
                        settle <= 1'b0;
                    end else if (grant_r) begin
                        state    <= S_RCMD;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= BASE_ADDR + ADDR_WIDTH'(rd_offs);
                        keep     <= 1'b1;
                    end
                end
                // Upstream data lags its ack by two cycles, so sample on the second settle cycle.
                S_WSETTLE: begin
                    if (settle) begin
                        state     <= S_WCMD;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= BASE_ADDR + ADDR_WIDTH'(wr_offs);
                        mem_wdata <= vidin_d;
                    end else begin
                        settle <= 1'b1;
                    end
                end
                S_WCMD: begin
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        vidin_ack <= 1'b1;
                        wcount    <= wcount + 4'd1;
                        state     <= S_WACK;
                    end
                end
                S_WACK: begin
                    settle <= 1'b0;
                    if (wcount == 4'd0) begin
                        state     <= S_IDLE;
                        win_block <= 1'b1;
`ifdef SCANDOUBLER_MEMBRIDGE_RR_EN
                        rr_last_write <= 1'b1;
`endif
                    end else begin
                        state <= S_WSETTLE;
                    end
                end
                S_RCMD: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        rcount  <= '0;
                        state   <= S_RDATA;
                    end
                end
                // keep is sticky-low: once the fetch is abandoned, the rest of the burst is drained silently.
                S_RDATA: begin
                    keep <= keep_next;
                    if (mem_rvalid) begin
                        vidout_d   <= mem_rdata;
                        vidout_ack <= keep_next;
                        rcount     <= rcount + 3'd1;
                        if (rcount == 3'd7) begin
                            state <= S_IDLE;
                            keep  <= 1'b0;
`ifdef SCANDOUBLER_MEMBRIDGE_RR_EN
                            rr_last_write <= 1'b0;
`endif
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
